// File: rtl/mips_mem_access_unit.sv
// Load/store bridge between the multicycle MIPS datapath and an Avalon-MM master port.
// Build option MIPS_MEM_ALIGN_CHECK_EN: misaligned requests return an error instead of rounding the lane offset down.
module mips_mem_access_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(BYTES);
  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [OFS_W-1:0]  off_raw, off_eff, nb_mask;
  logic [BYTES-1:0]  lane_en;
  logic [DATA_W-1:0] lane_bits, wdata_sh;
  logic              size_ok, req_ok;

  logic              write_q, signed_q;
  logic [1:0]        size_q;
  logic [OFS_W-1:0]  off_q;
  logic [DATA_W-1:0] rd_sh, load_ext;
  logic              sign_bit;

  logic [CNT_W-1:0]  wait_cnt, cnt_d;
  logic              read_d, write_d, rv_d, resp_ld, err_d, accept, timeout;
  logic [DATA_W-1:0] rdata_d;

  assign req_ready = rst && (state_q == IDLE);

  // Request decode: lane coverage, effective offset and validity.
  always_comb begin
    off_raw = req_addr[OFS_W-1:0];
    size_ok = (32'(req_size) <= OFS_W);
    for (int unsigned i = 0; i < OFS_W; i++) nb_mask[i] = (i < 32'(req_size));
    for (int unsigned i = 0; i < BYTES; i++) begin
      lane_en[i]          = (i < (32'd1 << req_size));
      lane_bits[8*i +: 8] = {8{lane_en[i]}};
    end
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    off_eff = off_raw;
    req_ok  = size_ok && ((off_raw & nb_mask) == '0);
`else
    off_eff = off_raw & ~nb_mask;
    req_ok  = size_ok;
`endif
    wdata_sh = (req_wdata & lane_bits) << {off_eff, 3'b000};
  end

  // Load path: bring the addressed lanes down to bit 0 and extend.
  always_comb begin
    rd_sh    = readdata >> {off_q, 3'b000};
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if ((32'd1 << size_q) == i + 1) sign_bit = rd_sh[8*i+7];
    end
    for (int unsigned i = 0; i < BYTES; i++) begin
      load_ext[8*i +: 8] = (i < (32'd1 << size_q)) ? rd_sh[8*i +: 8] : {8{sign_bit & signed_q}};
    end
  end

  assign timeout = waitrequest && (WAIT_LIMIT != 0) && (32'(wait_cnt) == WAIT_LIMIT - 1);

  always_comb begin
    state_d = state_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    rv_d    = 1'b0;
    resp_ld = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    cnt_d   = wait_cnt;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (req_ok) begin
            state_d = ACCESS;
            read_d  = !req_write;
            write_d = req_write;
          end else begin
            state_d = RESP;
            rv_d    = 1'b1;
            resp_ld = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        read_d  = read;
        write_d = write;
        if (!waitrequest) begin
          state_d = RESP;
          read_d  = 1'b0;
          write_d = 1'b0;
          rv_d    = 1'b1;
          resp_ld = 1'b1;
          rdata_d = write_q ? '0 : load_ext;
        end else if (timeout) begin
          state_d = RESP;
          read_d  = 1'b0;
          write_d = 1'b0;
          rv_d    = 1'b1;
          resp_ld = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Bus strobes, captured request fields and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
    end else begin
      read       <= read_d;
      write      <= write_d;
      resp_valid <= rv_d;
      wait_cnt   <= cnt_d;
      if (accept) begin
        address    <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        byteenable <= lane_en << off_eff;
        writedata  <= wdata_sh;
        write_q    <= req_write;
        signed_q   <= req_signed;
        size_q     <= req_size;
        off_q      <= off_eff;
      end
      if (resp_ld) begin
        resp_err   <= err_d;
        resp_rdata <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Randomised bench for mips_mem_access_unit against a transaction-level model, with pinned directed cases.
module tb_mips_mem_access_unit;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WAIT_LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest = 1'b0;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteenable;
  logic [DATA_W-1:0] readdata = '0;

  always #5 clk = ~clk;

  mips_mem_access_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Per-cycle expectations, written by the driver, checked by the compare process.
  logic        chk_en = 1'b0;
  logic        e_ready = 1'b0, e_read = 1'b0, e_write = 1'b0, e_rv = 1'b0, e_err = 1'b0, e_clr = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0, e_rdata = '0;
  logic [3:0]  e_be = '0;
  logic        lit_en = 1'b0, lit_err = 1'b0;
  logic [31:0] lit_addr = '0, lit_wd = '0, lit_rdata = '0;
  logic [3:0]  lit_be = '0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready", 64'(req_ready), 64'(e_ready));
      cmp("read", 64'(read), 64'(e_read));
      cmp("write", 64'(write), 64'(e_write));
      cmp("resp_valid", 64'(resp_valid), 64'(e_rv));
      if (e_read || e_write) begin
        cmp("address", 64'(address), 64'(e_addr));
        cmp("byteenable", 64'(byteenable), 64'(e_be));
        if (e_write) cmp("writedata", 64'(writedata), 64'(e_wd));
        if (lit_en) begin
          cmp("pinned_address", 64'(address), 64'(lit_addr));
          cmp("pinned_byteenable", 64'(byteenable), 64'(lit_be));
          if (e_write) cmp("pinned_writedata", 64'(writedata), 64'(lit_wd));
        end
      end
      if (e_rv) begin
        cmp("resp_rdata", 64'(resp_rdata), 64'(e_rdata));
        cmp("resp_err", 64'(resp_err), 64'(e_err));
        if (lit_en) begin
          cmp("pinned_rdata", 64'(resp_rdata), 64'(lit_rdata));
          cmp("pinned_err", 64'(resp_err), 64'(lit_err));
        end
      end
      if (e_clr) begin
        cmp("reset_address", 64'(address), 64'd0);
        cmp("reset_byteenable", 64'(byteenable), 64'd0);
        cmp("reset_writedata", 64'(writedata), 64'd0);
        cmp("reset_rdata", 64'(resp_rdata), 64'd0);
        cmp("reset_err", 64'(resp_err), 64'd0);
      end
    end
  end

  // Reference: what a single access must look like on the bus and in the response.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wdat, input logic [31:0] rdat,
                                output logic ok, output logic [31:0] m_addr, output logic [3:0] m_be,
                                output logic [31:0] m_wd, output logic [31:0] m_ld);
    int          nb, off;
    logic [63:0] lm, sh;
    nb  = 1 << sz;
    off = int'(a[1:0]);
    ok  = (sz <= 2'd2);
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    if (off % nb != 0) ok = 1'b0;
`else
    off = off - (off % nb);
`endif
    m_addr = a - (a % 32'd4);
    m_be   = 4'(((1 << nb) - 1) << off);
    lm     = (64'd1 << (8 * nb)) - 64'd1;
    m_wd   = 32'((64'(wdat) & lm) << (8 * off));
    sh     = (64'(rdat) >> (8 * off)) & lm;
    if (sg && sh[8*nb-1]) sh = sh | ~lm;
    m_ld   = wr ? 32'd0 : 32'(sh);
  endfunction

  task automatic pin(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input logic [31:0] rd, input logic err);
    lit_en = 1'b1; lit_addr = a; lit_be = be; lit_wd = wd; lit_rdata = rd; lit_err = err;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      req_valid = 1'b0;
      e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rv = 1'b0;
      waitrequest = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] wdat, input logic [31:0] rdat, input int nwait);
    logic        ok, tmo;
    logic [31:0] m_addr, m_wd, m_ld;
    logic [3:0]  m_be;
    int          k;
    model(wr, sz, sg, a, wdat, rdat, ok, m_addr, m_be, m_wd, m_ld);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wdat; waitrequest = 1'($urandom);
    e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rv = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    e_ready = 1'b0;
    if (ok) begin
      tmo = (nwait >= int'(WAIT_LIMIT));
      k   = tmo ? int'(WAIT_LIMIT) : nwait + 1;
      for (int j = 1; j <= k; j++) begin
        e_read = !wr; e_write = wr; e_addr = m_addr; e_be = m_be; e_wd = m_wd;
        waitrequest = (j <= nwait);
        readdata    = (j <= nwait) ? $urandom : rdat;
        @(posedge clk); #1;
      end
      e_read = 1'b0; e_write = 1'b0;
      e_rv = 1'b1; e_err = tmo; e_rdata = tmo ? 32'd0 : m_ld;
    end else begin
      e_rv = 1'b1; e_err = 1'b1; e_rdata = 32'd0;
    end
    waitrequest = 1'($urandom); readdata = $urandom;
    @(posedge clk); #1;
    e_rv = 1'b0; e_ready = 1'b1; lit_en = 1'b0;
  endtask

  initial begin
    int nw, r;
    logic [1:0] sz;
    // Reset state
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1; e_ready = 1'b0; e_clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; e_ready = 1'b1;
    @(posedge clk); #1;
    e_clr = 1'b0;
    idle(1);

    // Store byte, zero wait states
    pin(32'h1000, 4'b1000, 32'hAB00_0000, 32'h0, 1'b0);
    txn(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, $urandom, 0);
    // Signed half load with three wait states
    pin(32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
    txn(1'b0, 2'd1, 1'b1, 32'h2002, $urandom, 32'h8001_1234, 3);
    // Byte load, unsigned then signed
    pin(32'h2000, 4'b0010, 32'h0, 32'h0000_00F0, 1'b0);
    txn(1'b0, 2'd0, 1'b0, 32'h2001, $urandom, 32'h1234_F0AB, 0);
    pin(32'h2000, 4'b0010, 32'h0, 32'hFFFF_FFF0, 1'b0);
    txn(1'b0, 2'd0, 1'b1, 32'h2001, $urandom, 32'h1234_F0AB, 1);
    // Wait timeout, then a normal access right after
    pin(32'h4000, 4'b1111, 32'h0, 32'h0, 1'b1);
    txn(1'b0, 2'd2, 1'b0, 32'h4000, $urandom, 32'h5555_AAAA, 20);
    pin(32'h4004, 4'b0011, 32'h0000_BEEF, 32'h0, 1'b0);
    txn(1'b1, 2'd1, 1'b0, 32'h4004, 32'h1234_BEEF, $urandom, 7);
    // Misaligned word load
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    pin(32'h3000, 4'b1111, 32'h0, 32'h0, 1'b1);
`else
    pin(32'h3000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
`endif
    txn(1'b0, 2'd2, 1'b0, 32'h3002, $urandom, 32'hCAFE_F00D, 0);
    // Oversized access
    pin(32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn(1'b0, 2'd3, 1'b0, 32'h6000, $urandom, $urandom, 0);

    // Reset while a read is stalled
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h5000;
    e_ready = 1'b1; e_read = 1'b0; e_write = 1'b0; e_rv = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; e_ready = 1'b0;
    waitrequest = 1'b1; e_read = 1'b1; e_addr = 32'h5000; e_be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; e_read = 1'b0; e_ready = 1'b1; e_clr = 1'b1;
    @(posedge clk); #1;
    e_clr = 1'b0;
    pin(32'h5008, 4'b1111, 32'h0, 32'h0102_0304, 1'b0);
    txn(1'b0, 2'd2, 1'b0, 32'h5008, $urandom, 32'h0102_0304, 2);

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       nw = int'($urandom_range(0, 3));
      else if (r == 7) nw = int'(WAIT_LIMIT) - 1;
      else             nw = int'($urandom_range(8, 11));
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom, nw);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
